stat_display: RTL



---
 rtl/stat_display_pkg.sv | 33 +++
 rtl/seg7_hex_decoder.sv | 16 +
 rtl/stat_display.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/stat_display_pkg.sv
// rtl/stat_display_pkg.sv - shared page encodings and hex segment table for stat_display
//
// Purpose: page index encoding, page count, the 16-entry 7-segment table
//          {g,f,e,d,c,b,a} (active-high) and the page-advance helper.
// Ports:   none (package)

package stat_display_pkg;

  typedef enum logic [2:0] {
    PAGE_STATUS  = 3'd0,
    PAGE_HUNGER  = 3'd1,
    PAGE_HAPPY   = 3'd2,
    PAGE_HEALTH  = 3'd3,
    PAGE_HYGIENE = 3'd4,
    PAGE_ENERGY  = 3'd5
  } page_e;

  localparam int NUM_PAGES = 6;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Page sequence wraps from the last stat page back to the status page.
  function automatic page_e next_page(input page_e p);
    if (p == page_e'(NUM_PAGES - 1)) return PAGE_STATUS;
    return page_e'(p + 3'd1);
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - combinational hex digit to 7-segment decoder
//
// Purpose: maps a 4-bit value to its hex glyph, segments {g,f,e,d,c,b,a}.
// Ports:   digit (in, 4)  value to show
//          seg   (out, 7) active-high segment pattern

module seg7_hex_decoder
  import stat_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[digit];

endmodule

// File: rtl/stat_display.sv
// rtl/stat_display.sv - paged 7-segment viewer for pet stats and status vector
//
// Purpose: cycles the display through a status page and five stat pages,
//          auto-advancing every DWELL_TICKS cycles or on a button edge, and
//          blinks the decimal point when the shown item is critical.
// Ports:   clk, rst_n (async active-low), ena (freeze + blank when low)
//          hunger/happiness/health/hygiene/energy (in, 4) stat values
//          status (in, 7) raw segment pattern for the status page
//          btn_next, btn_hold (in, async raw buttons)
//          seg (out, 7), dp, page (out, 3), alert - all registered

module stat_display
  import stat_display_pkg::*;
#(
  parameter logic [23:0] DWELL_TICKS = 24'd10_000_000,
  parameter logic [23:0] BLINK_DIV   = 24'd2_500_000,
  parameter logic [3:0]  ALERT_LOW   = 4'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] hunger,
  input  logic [3:0] happiness,
  input  logic [3:0] health,
  input  logic [3:0] hygiene,
  input  logic [3:0] energy,
  input  logic [6:0] status,
  input  logic       btn_next,
  input  logic       btn_hold,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] page,
  output logic       alert
);

  logic        next_meta, next_s, next_s_d;
  logic        hold_meta, hold_s;
  logic        next_edge, dwell_done;
  logic [23:0] dwell_cnt, blink_cnt;
  logic        blink_phase;
  page_e       page_q;
  logic        hunger_crit, happy_crit, health_crit, hygiene_crit, energy_crit;
  logic        any_crit;
  logic [3:0]  cur_stat;
  logic        cur_crit;
  logic [6:0]  stat_seg;
  logic [6:0]  seg_q;
  logic        dp_q, alert_q;

  // Synchronizers run regardless of ena so a held button is seen promptly
  // once the design is re-enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_meta <= 1'b0;
      next_s    <= 1'b0;
      next_s_d  <= 1'b0;
      hold_meta <= 1'b0;
      hold_s    <= 1'b0;
    end else begin
      next_meta <= btn_next;
      next_s    <= next_meta;
      next_s_d  <= next_s;
      hold_meta <= btn_hold;
      hold_s    <= hold_meta;
    end
  end

  assign next_edge  = next_s & ~next_s_d;
  assign dwell_done = ~hold_s && (dwell_cnt == DWELL_TICKS - 24'd1);

  // A manual edge and a dwell expiry on the same cycle merge into one advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_q      <= PAGE_STATUS;
      dwell_cnt   <= 24'd0;
      blink_cnt   <= 24'd0;
      blink_phase <= 1'b0;
    end else if (ena) begin
      if (next_edge || dwell_done) begin
        page_q    <= next_page(page_q);
        dwell_cnt <= 24'd0;
      end else if (!hold_s) begin
        dwell_cnt <= dwell_cnt + 24'd1;
      end
      if (blink_cnt == BLINK_DIV - 24'd1) begin
        blink_cnt   <= 24'd0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 24'd1;
      end
    end
  end

  // Hunger is bad when high; every other stat is bad when low.
  assign hunger_crit  = hunger >= (4'd15 - ALERT_LOW);
  assign happy_crit   = happiness <= ALERT_LOW;
  assign health_crit  = health <= ALERT_LOW;
  assign hygiene_crit = hygiene <= ALERT_LOW;
  assign energy_crit  = energy <= ALERT_LOW;
  assign any_crit     = hunger_crit | happy_crit | health_crit | hygiene_crit | energy_crit;

  always_comb begin
    cur_stat = 4'd0;
    cur_crit = 1'b0;
    case (page_q)
      PAGE_HUNGER:  begin cur_stat = hunger;    cur_crit = hunger_crit;  end
      PAGE_HAPPY:   begin cur_stat = happiness; cur_crit = happy_crit;   end
      PAGE_HEALTH:  begin cur_stat = health;    cur_crit = health_crit;  end
      PAGE_HYGIENE: begin cur_stat = hygiene;   cur_crit = hygiene_crit; end
      PAGE_ENERGY:  begin cur_stat = energy;    cur_crit = energy_crit;  end
      default:      begin cur_stat = 4'd0;      cur_crit = 1'b0;         end
    endcase
  end

  seg7_hex_decoder u_hex (
    .digit (cur_stat),
    .seg   (stat_seg)
  );

  // The status page blinks dp on the registered alert, so it trails the
  // stat inputs by one extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= 7'd0;
      dp_q    <= 1'b0;
      alert_q <= 1'b0;
    end else if (ena) begin
      alert_q <= any_crit;
      if (page_q == PAGE_STATUS) begin
        seg_q <= status;
        dp_q  <= alert_q & blink_phase;
      end else begin
        seg_q <= stat_seg;
        dp_q  <= cur_crit & blink_phase;
      end
    end else begin
      seg_q   <= 7'd0;
      dp_q    <= 1'b0;
      alert_q <= 1'b0;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign alert = alert_q;
  assign page  = page_q;

endmodule
